// File: rtl/adc_conv_arbiter.sv
// Shares one SAR conversion engine between NREQ requesters. Priority-masked round-robin
// arbitration, channel settle, stale-eoc rejection, timeout, and a registered result return.
module adc_conv_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 10,
  parameter int SETTLE_W = 4,
  parameter int TMO_W    = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   req_ch,
  input  logic [NREQ-1:0]     hi_pri,
  input  logic [SETTLE_W-1:0] settle,
  input  logic [TMO_W-1:0]    tmo,
  input  logic                eoc,
  input  logic [DW-1:0]       adc_data,
  output logic [2:0]          ch_sel,
  output logic                soc,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic [NREQ-1:0]     err,
  output logic [DW-1:0]       rdata,
  output logic                busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, RESP} state_t;
  state_t state, nxt;

  logic [PW-1:0]       rr_ptr, win;
  logic [NREQ-1:0]     cand;
  logic                found;
  logic [2:0]          win_ch, last_ch;
  logic                last_ch_valid;
  logic [SETTLE_W-1:0] settle_ctr;
  logic [TMO_W-1:0]    tmo_ctr;
  logic                arb, tmo_hit;

  // High-priority requesters mask out the rest; round-robin scan starts at rr_ptr.
  always_comb begin
    cand  = (|(req & hi_pri)) ? (req & hi_pri) : req;
    win   = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && cand[(int'(rr_ptr) + i) % NREQ]) begin
        win   = PW'((int'(rr_ptr) + i) % NREQ);
        found = 1'b1;
      end
    end
    win_ch = req_ch[3*int'(win) +: 3];
  end

  assign arb     = (state == IDLE) && en && (|req);
  assign tmo_hit = (state == WAIT) && !eoc && (tmo != '0) && (tmo_ctr == tmo - TMO_W'(1));

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (arb)
              nxt = ((!last_ch_valid || win_ch != last_ch) && settle != '0) ? SETTLE : START;
      SETTLE: if (settle_ctr == settle - SETTLE_W'(1)) nxt = START;
      // A leftover eoc from the previous conversion must clear before we trust it.
      START:  if (!eoc) nxt = WAIT;
      WAIT:   if (eoc) nxt = RESP;
              else if (tmo_hit) nxt = IDLE;
      RESP:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      last_ch       <= '0;
      last_ch_valid <= 1'b0;
      settle_ctr    <= '0;
      tmo_ctr       <= '0;
      ch_sel        <= '0;
      soc           <= 1'b0;
      grant         <= '0;
      done          <= '0;
      err           <= '0;
      rdata         <= '0;
      busy          <= 1'b0;
    end else begin
      state <= nxt;
      soc   <= (nxt == START) || (nxt == WAIT);
      busy  <= (nxt != IDLE);
      done  <= '0;
      err   <= '0;

      if (nxt != state) begin
        settle_ctr <= '0;
        tmo_ctr    <= '0;
      end else begin
        if (state == SETTLE && settle_ctr != '1) settle_ctr <= settle_ctr + SETTLE_W'(1);
        if (state == WAIT && tmo_ctr != '1)      tmo_ctr    <= tmo_ctr + TMO_W'(1);
      end

      if (arb) begin
        grant  <= NREQ'(1) << win;
        ch_sel <= win_ch;
        rr_ptr <= PW'((int'(win) + 1) % NREQ);
      end

      if (state == WAIT && eoc) begin
        rdata         <= adc_data;
        last_ch       <= ch_sel;
        last_ch_valid <= 1'b1;
        done          <= grant;
      end

      // Timed-out channel state is unknown, so force a settle next time.
      if (tmo_hit) begin
        err           <= grant;
        grant         <= '0;
        last_ch_valid <= 1'b0;
      end

      if (state == RESP) grant <= '0;
    end
  end
endmodule

// File: tb/tb_adc_conv_arbiter.sv
// Directed bench for adc_conv_arbiter: stimulus pushes expected completions, a monitor
// pops and compares them whenever done or err pulses.
module tb_adc_conv_arbiter;
  logic        clk, rst_n, en, eoc, soc, busy;
  logic [3:0]  req, hi_pri, grant, done, err;
  logic [11:0] req_ch;
  logic [3:0]  settle;
  logic [11:0] tmo;
  logic [9:0]  adc_data, rdata;
  logic [2:0]  ch_sel;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic       is_err;
    logic [3:0] g;
    logic [9:0] d;
  } exp_t;
  exp_t sbq[$];

  adc_conv_arbiter #(.NREQ(4), .DW(10), .SETTLE_W(4), .TMO_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_ch(req_ch), .hi_pri(hi_pri),
    .settle(settle), .tmo(tmo), .eoc(eoc), .adc_data(adc_data), .ch_sel(ch_sel),
    .soc(soc), .grant(grant), .done(done), .err(err), .rdata(rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (|done || |err)) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_event: done=%b err=%b with nothing expected", done, err);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (!e.is_err) begin
          check("resp done", 32'(done), 32'(e.g));
          check("resp rdata", 32'(rdata), 32'(e.d));
          check("resp no_err", 32'(err), 32'(0));
        end else begin
          check("tmo err", 32'(err), 32'(e.g));
          check("tmo no_done", 32'(done), 32'(0));
          check("tmo soc_low", 32'(soc), 32'(0));
          check("tmo grant_clr", 32'(grant), 32'(0));
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; req = '0; req_ch = '0; hi_pri = '0;
    settle = '0; tmo = '0; eoc = 1'b0; adc_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic convert(input string nm, input logic [3:0] exp_g, input logic [2:0] exp_ch,
                         input int exp_settle, input logic [9:0] data);
    int n;
    exp_t e;
    n = 0;
    while (grant == '0 && n < 100) begin tick(); n++; end
    check({nm, " grant"}, 32'(grant), 32'(exp_g));
    check({nm, " ch_sel"}, 32'(ch_sel), 32'(exp_ch));
    n = 0;
    while (!soc && n < 100) begin tick(); n++; end
    check({nm, " settle_cycles"}, n, exp_settle);
    e.is_err = 1'b0; e.g = exp_g; e.d = data;
    sbq.push_back(e);
    tick();
    eoc = 1'b1; adc_data = data;
    n = 0;
    while (done == '0 && n < 100) begin tick(); n++; end
    check({nm, " done_seen"}, 32'(n < 100), 32'(1));
    eoc = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    logic seen;
    exp_t e;

    // Reset values
    apply_reset();
    check("rst grant", 32'(grant), 32'(0));
    check("rst outs", {done, err, soc, busy, ch_sel}, 32'(0));
    check("rst rdata", 32'(rdata), 32'(0));

    // Single request, first use of channel 5 settles 3 cycles
    en = 1'b1; settle = 4'd3; req_ch = 12'd5; req = 4'b0001;
    convert("single", 4'b0001, 3'd5, 3, 10'h2A5);
    req = '0;
    check("single busy_after", 32'(busy), 32'(0));
    check("single grant_after", 32'(grant), 32'(0));
    check("single rdata_hold", 32'(rdata), 32'h2A5);

    // Round-robin, same channel after the first conversion needs no settle
    apply_reset();
    en = 1'b1; settle = 4'd3; req_ch = {3'd2, 3'd2, 3'd2, 3'd2}; req = 4'b1111;
    convert("rr0", 4'b0001, 3'd2, 3, 10'h011);
    convert("rr1", 4'b0010, 3'd2, 0, 10'h022);
    convert("rr2", 4'b0100, 3'd2, 0, 10'h033);
    convert("rr3", 4'b1000, 3'd2, 0, 10'h044);
    convert("rr4", 4'b0001, 3'd2, 0, 10'h055);
    req = '0;

    // Priority mask, then round-robin wraps from 3 to 0
    apply_reset();
    en = 1'b1; req_ch = {3'd1, 3'd1, 3'd1, 3'd1}; req = 4'b0111; hi_pri = 4'b0100;
    convert("pri_hi", 4'b0100, 3'd1, 0, 10'h101);
    hi_pri = '0;
    convert("pri_rr", 4'b0001, 3'd1, 0, 10'h102);
    req = '0;

    // Timeout: err exactly 20 cycles after WAIT entry, then the retry settles again
    apply_reset();
    en = 1'b1; settle = 4'd3; tmo = 12'd20; req_ch = 12'd5; req = 4'b0001;
    n = 0;
    while (!soc && n < 100) begin tick(); n++; end
    check("tmo settle_cycles", n, 4);
    e.is_err = 1'b1; e.g = 4'b0001; e.d = '0;
    sbq.push_back(e);
    tick();
    n = 0;
    while (err == '0 && n < 100) begin tick(); n++; end
    check("tmo cycles", n, 20);
    convert("tmo_retry", 4'b0001, 3'd5, 3, 10'h0CC);
    req = '0; tmo = '0;

    // Stale eoc held through START is ignored
    apply_reset();
    en = 1'b1; req_ch = {3'd0, 3'd0, 3'd3, 3'd0}; req = 4'b0010;
    eoc = 1'b1; adc_data = 10'h3FF;
    n = 0;
    while (grant == '0 && n < 100) begin tick(); n++; end
    check("stale grant", 32'(grant), 32'(4'b0010));
    seen = soc;
    for (int i = 0; i < 3; i++) begin tick(); seen = seen & soc & (done == '0); end
    check("stale hold_start", 32'(seen), 32'(1));
    eoc = 1'b0;
    check("stale no_capture", 32'(rdata), 32'(0));
    e.is_err = 1'b0; e.g = 4'b0010; e.d = 10'h155;
    sbq.push_back(e);
    tick();
    eoc = 1'b1; adc_data = 10'h155;
    n = 0;
    while (done == '0 && n < 100) begin tick(); n++; end
    check("stale done_seen", 32'(n < 100), 32'(1));
    eoc = 1'b0; req = '0;
    tick();

    // Reset mid-WAIT aborts silently; en=0 blocks grants
    apply_reset();
    en = 1'b1; req_ch = 12'd4; req = 4'b0001;
    n = 0;
    while (!soc && n < 100) begin tick(); n++; end
    tick();
    check("abort in_wait", 32'(soc & busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("abort outs", {grant, done, err, soc, busy, ch_sel}, 32'(0));
    check("abort rdata", 32'(rdata), 32'(0));
    en = 1'b0; req = 4'b1111;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); seen = seen | busy | (|grant); end
    check("en_off idle", 32'(seen), 32'(0));
    req = '0;

    repeat (3) tick();
    check("sb drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end
endmodule
